concat_fill_sched: RTL and testbench

CONCAT_FILL_SCHED -- requirements
Module: concat_fill_sched

---
 rtl/concat_fill_pkg.sv | 14 +
 rtl/concat_fill_arb.sv | 68 ++++++
 rtl/concat_fill_sched.sv | 127 ++++++++++++
 tb/tb_concat_fill_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/concat_fill_pkg.sv
// Shared types and default widths for the concat-fill scheduler.
package concat_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_NREQ   = 2;

endpackage

// File: rtl/concat_fill_arb.sv
// Requester arbiter: round-robin by default, fixed lowest-index priority when
// CONCAT_FILL_SCHED_FIXED_PRIO_EN is defined.
module concat_fill_arb
  import concat_fill_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

`ifdef CONCAT_FILL_SCHED_FIXED_PRIO_EN

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, advance, found};

`else

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  // Search starts at the pointer and wraps, so the last winner goes last.
  always_comb begin
    grant = '0;
    win   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

`endif

endmodule

// File: rtl/concat_fill_sched.sv
// Pattern-replication fill scheduler: arbitrates requesters, shifts in copies of
// the winner's pattern, holds the result. Option: CONCAT_FILL_SCHED_FIXED_PRIO_EN.
module concat_fill_sched
  import concat_fill_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int PAT_W  = DEF_PAT_W,
  parameter  int NREQ   = DEF_NREQ,
  localparam int CW     = $clog2(DATA_W / PAT_W + 1),
  localparam int IW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*PAT_W-1:0] req_pat,
  input  logic [NREQ*CW-1:0]   req_cnt,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [IW-1:0]        out_id,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int             NCOPY   = DATA_W / PAT_W;
  localparam logic [CW-1:0]  MAX_CNT = CW'(NCOPY);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q;
  logic [PAT_W-1:0]    pat_q;
  logic [CW-1:0]       rem_q;
  logic [IW-1:0]       id_q;

  logic [NREQ-1:0]     grant;
  logic                accept;
  logic [PAT_W-1:0]    sel_pat;
  logic [CW-1:0]       sel_cnt;
  logic [CW-1:0]       sel_cnt_sat;
  logic [IW-1:0]       sel_id;

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  assign accept = (state_q == IDLE) && (|req_valid);

  concat_fill_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    sel_pat = '0;
    sel_cnt = '0;
    sel_id  = '0;
    for (int g = 0; g < NREQ; g++) begin
      if (grant[g]) begin
        sel_pat = req_pat[g*PAT_W +: PAT_W];
        sel_cnt = req_cnt[g*CW +: CW];
        sel_id  = IW'(g);
      end
    end
  end

  assign sel_cnt_sat = sat_cnt(sel_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // req_ready is gated by rst_n so no grant leaks out while reset is held.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          req_ready = grant & {NREQ{rst_n}};
          state_d   = (sel_cnt_sat == '0) ? HOLD : BUILD;
        end
      end
      BUILD: begin
        if (rem_q <= CW'(1)) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pat_q <= '0;
      rem_q <= '0;
      id_q  <= '0;
    end else if (accept) begin
      acc_q <= '0;
      pat_q <= sel_pat;
      rem_q <= sel_cnt_sat;
      id_q  <= sel_id;
    end else if (state_q == BUILD) begin
      acc_q <= {acc_q[DATA_W-PAT_W-1:0], pat_q};
      rem_q <= rem_q - CW'(1);
    end
  end

  assign out_data = acc_q;
  assign out_id   = id_q;

endmodule

// File: tb/tb_concat_fill_sched.sv
// Scoreboard bench for concat_fill_sched: random and directed fill commands
// checked against a behavioural replication/arbitration model.
module tb_concat_fill_sched;

  localparam int DATA_W = 32;
  localparam int PAT_W  = 4;
  localparam int NREQ   = 2;
  localparam int CW     = $clog2(DATA_W / PAT_W + 1);
  localparam int IW     = $clog2(NREQ);
  localparam int NCOPY  = DATA_W / PAT_W;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*PAT_W-1:0] req_pat;
  logic [NREQ*CW-1:0]    req_cnt;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic [IW-1:0]         out_id;
  logic                  out_ready;
  logic                  busy;

  concat_fill_sched #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .NREQ   (NREQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pat   (req_pat),
    .req_cnt   (req_cnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [CW-1:0]    cnt;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IW-1:0]     id;
    logic [31:0]       vcyc;
  } exp_t;

  cmd_t cq[NREQ][$];
  exp_t sb[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   m_ptr = 0;
  logic m_idle = 1'b1;

  int   ready_mode;
  logic withdraw;
  logic drain_timeout;
  logic final_chk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Copies laid side by side from bit 0 upward; count saturates at NCOPY.
  function automatic logic [DATA_W-1:0] model_fill(input logic [PAT_W-1:0] p, input logic [CW-1:0] c);
    logic [DATA_W-1:0] d;
    int n;
    d = '0;
    n = (int'(c) > NCOPY) ? NCOPY : int'(c);
    for (int i = 0; i < n; i++) d = d | (DATA_W'(p) << (PAT_W * i));
    return d;
  endfunction

  function automatic logic [NREQ-1:0] arb_model(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] r;
    r = '0;
`ifdef CONCAT_FILL_SCHED_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = NREQ'(1) << i;
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      int k;
      k = (ptr + i) % NREQ;
      if (v[k]) r = NREQ'(1) << k;
    end
`endif
    return r;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] eg;
    logic            ev;
    int              w;
    int              n;
    exp_t            e;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_id", out_id, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      sb.delete();
      m_idle = 1'b1;
      m_ptr  = 0;
    end else begin
      check("busy", busy, !m_idle);
      eg = '0;
      if (m_idle && (|req_valid)) eg = arb_model(req_valid, m_ptr);
      check("req_ready", req_ready, eg);
      if (eg != '0) begin
        w = 0;
        for (int i = 0; i < NREQ; i++) if (eg[i]) w = i;
        n = (int'(req_cnt[w*CW +: CW]) > NCOPY) ? NCOPY : int'(req_cnt[w*CW +: CW]);
        e.data = model_fill(req_pat[w*PAT_W +: PAT_W], req_cnt[w*CW +: CW]);
        e.id   = IW'(w);
        e.vcyc = 32'(cyc + n + 1);
        sb.push_back(e);
        m_idle = 1'b0;
        m_ptr  = (w + 1) % NREQ;
      end
      ev = (sb.size() != 0) && (cyc >= int'(sb[0].vcyc));
      check("out_valid", out_valid, ev);
      if (out_valid && ev) begin
        check("out_data", out_data, sb[0].data);
        check("out_id", out_id, sb[0].id);
        if (out_ready) begin
          void'(sb.pop_front());
          m_idle = 1'b1;
        end
      end
      if (final_chk) begin
        check("sb_empty", sb.size(), 0);
        check("drain_timeout", drain_timeout, 0);
      end
    end
  end

  task automatic push(input int g, input logic [PAT_W-1:0] p, input logic [CW-1:0] c);
    cmd_t x;
    x.pat = p;
    x.cnt = c;
    cq[g].push_back(x);
  endtask

  // One cycle of stimulus: pop accepted commands, present heads, drive out_ready.
  task automatic step();
    logic [NREQ-1:0] rdy;
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1;
    for (int g = 0; g < NREQ; g++) begin
      if (rdy[g] && cq[g].size() > 0) void'(cq[g].pop_front());
      if (cq[g].size() > 0 && !(withdraw && $urandom_range(3) == 0)) begin
        req_valid[g]               = 1'b1;
        req_pat[g*PAT_W +: PAT_W]  = cq[g][0].pat;
        req_cnt[g*CW +: CW]        = cq[g][0].cnt;
      end else begin
        req_valid[g]               = 1'b0;
        req_pat[g*PAT_W +: PAT_W]  = PAT_W'($urandom);
        req_cnt[g*CW +: CW]        = CW'($urandom);
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
  endtask

  function automatic logic all_empty();
    logic r;
    r = (sb.size() == 0) && !out_valid;
    for (int g = 0; g < NREQ; g++) if (cq[g].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (k < bound && !all_empty()) begin
      step();
      k++;
    end
    if (!all_empty()) begin
      drain_timeout = 1'b1;
      $display("FAIL drain: queues not empty after %0d cycles", bound);
    end
    step();
  endtask

  initial begin
    int k;
    rst_n         = 1'b0;
    req_valid     = '0;
    req_pat       = '0;
    req_cnt       = '0;
    out_ready     = 1'b1;
    ready_mode    = 0;
    withdraw      = 1'b0;
    drain_timeout = 1'b0;
    final_chk     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters continuously valid from a fresh pointer.
    push(0, 4'h1, 4'd3);
    push(0, 4'h2, 4'd1);
    push(1, 4'h3, 4'd2);
    push(1, 4'h4, 4'd0);
    drain(200);

    push(0, 4'hA, 4'd8);  drain(100);
    push(1, 4'h5, 4'd2);  drain(100);
    push(1, 4'h7, 4'd0);  drain(100);
    push(0, 4'h3, 4'd15); drain(100);
    push(0, 4'h3, 4'd8);  drain(100);

    // Result held while out_ready stays low; a waiting requester is not granted.
    ready_mode = 2;
    push(0, 4'h9, 4'd3);
    k = 0;
    while (k < 60 && !out_valid) begin
      step();
      k++;
    end
    if (!out_valid) begin
      drain_timeout = 1'b1;
      $display("FAIL hold_wait: out_valid never rose");
    end
    push(1, 4'h6, 4'd4);
    repeat (5) step();
    ready_mode = 0;
    drain(100);

    // Randomized traffic with backpressure and withdrawn requests.
    ready_mode = 1;
    withdraw   = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push(int'($urandom_range(NREQ - 1)), PAT_W'($urandom), CW'($urandom_range(15)));
      repeat ($urandom_range(3)) step();
    end
    drain(4000);
    ready_mode = 0;
    withdraw   = 1'b0;

    // Reset pulsed in the middle of a BUILD.
    push(0, 4'hF, 4'd8);
    k = 0;
    while (k < 20 && !busy) begin
      step();
      k++;
    end
    repeat (3) step();
    for (int g = 0; g < NREQ; g++) cq[g].delete();
    step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (15) step();

    push(1, 4'hC, 4'd5);
    drain(100);

    final_chk = 1'b1;
    step();
    final_chk = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
